// File: rtl/dpram_be_clr.sv
// True dual-port register RAM with byte write enables, read-during-write mode select,
// same-address collision arbitration (port A wins per lane) and a reset-triggered clear sweep.
module dpram_be_clr #(
    parameter int unsigned         A_WIDTH  = 4,
    parameter int unsigned         D_WIDTH  = 16,
    parameter int unsigned         RD_MODE  = 0,
    parameter logic [D_WIDTH-1:0]  INIT_VAL = '0
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   ENA,
    input  logic [D_WIDTH/8-1:0]   WEA,
    input  logic [A_WIDTH-1:0]     ADDRA,
    input  logic [D_WIDTH-1:0]     DIA,
    output logic [D_WIDTH-1:0]     DOA,
    input  logic                   ENB,
    input  logic [D_WIDTH/8-1:0]   WEB,
    input  logic [A_WIDTH-1:0]     ADDRB,
    input  logic [D_WIDTH-1:0]     DIB,
    output logic [D_WIDTH-1:0]     DOB,
    output logic                   RDY,
    output logic                   COLL
);

    localparam int unsigned NB    = D_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** A_WIDTH;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic               state;
    logic [A_WIDTH-1:0] ptr;

    logic [D_WIDTH-1:0] old_a, old_b;
    logic [D_WIDTH-1:0] merge_c, new_a, new_b;
    logic               same_addr, wr_a, wr_b, lane_clash;

    // Resolve byte merge and arbitration up front so each address sees one write per edge.
    always_comb begin
        old_a      = mem[ADDRA];
        old_b      = mem[ADDRB];
        same_addr  = ENA && ENB && (ADDRA == ADDRB);
        wr_a       = ENA && (|WEA);
        wr_b       = ENB && (|WEB);
        lane_clash = same_addr && (|(WEA & WEB));
        merge_c    = old_a;
        new_a      = old_a;
        new_b      = old_b;
        for (int i = 0; i < NB; i++) begin
            if (WEA[i]) begin
                new_a[8*i +: 8]   = DIA[8*i +: 8];
                merge_c[8*i +: 8] = DIA[8*i +: 8];
            end else if (WEB[i]) begin
                merge_c[8*i +: 8] = DIB[8*i +: 8];
            end
            if (WEB[i]) begin
                new_b[8*i +: 8] = DIB[8*i +: 8];
            end
        end
        if (same_addr) begin
            new_a = merge_c;
            new_b = merge_c;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= INIT_VAL;
            end else if (same_addr) begin
                if (wr_a || wr_b) begin
                    mem[ADDRA] <= merge_c;
                end
            end else begin
                if (wr_a) begin
                    mem[ADDRA] <= new_a;
                end
                if (wr_b) begin
                    mem[ADDRB] <= new_b;
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            DOA   <= '0;
            DOB   <= '0;
            COLL  <= 1'b0;
        end else if (state == ST_CLEAR) begin
            ptr  <= ptr + 1'b1;
            COLL <= 1'b0;
            if (ptr == A_WIDTH'(DEPTH - 1)) begin
                state <= ST_READY;
            end
        end else begin
            COLL <= lane_clash;
            // A reader that is not itself writing always sees the pre-edge word.
            if (ENA) begin
                DOA <= (RD_MODE == 0 && wr_a) ? new_a : old_a;
            end
            if (ENB) begin
                DOB <= (RD_MODE == 0 && wr_b) ? new_b : old_b;
            end
        end
    end

    assign RDY = (state == ST_READY);

endmodule

// File: tb/tb_dpram_be_clr.sv
// Drives two dpram_be_clr instances (write-first and read-first) with shared stimulus and
// compares both against a word/lane-level reference model every cycle.
module tb_dpram_be_clr;

    localparam logic [15:0] INIT = 16'hA5A5;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        ENA = 1'b0, ENB = 1'b0;
    logic [1:0]  WEA = '0, WEB = '0;
    logic [3:0]  ADDRA = '0, ADDRB = '0;
    logic [15:0] DIA = '0, DIB = '0;

    logic [15:0] doa0, dob0, doa1, dob1;
    logic        rdy0, coll0, rdy1, coll1;

    always #5 CLOCK = ~CLOCK;

    dpram_be_clr #(.A_WIDTH(4), .D_WIDTH(16), .RD_MODE(0), .INIT_VAL(INIT)) u_dut0 (
        .CLOCK(CLOCK), .RESET(RESET),
        .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa0),
        .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob0),
        .RDY(rdy0), .COLL(coll0)
    );

    dpram_be_clr #(.A_WIDTH(4), .D_WIDTH(16), .RD_MODE(1), .INIT_VAL(INIT)) u_dut1 (
        .CLOCK(CLOCK), .RESET(RESET),
        .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa1),
        .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob1),
        .RDY(rdy1), .COLL(coll1)
    );

    // Reference model state
    logic [15:0] m_mem [16];
    logic [3:0]  m_ptr = '0;
    logic        m_rdy = 1'b0;
    logic        m_coll = 1'b0;
    logic [15:0] m_doa0 = '0, m_dob0 = '0, m_doa1 = '0, m_dob1 = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [15:0] old [16];
        if (RESET) begin
            m_ptr  = '0;
            m_rdy  = 1'b0;
            m_coll = 1'b0;
            m_doa0 = '0; m_dob0 = '0; m_doa1 = '0; m_dob1 = '0;
        end else if (!m_rdy) begin
            m_mem[m_ptr] = INIT;
            if (m_ptr == 4'd15) m_rdy = 1'b1;
            m_ptr  = m_ptr + 4'd1;
            m_coll = 1'b0;
        end else begin
            old = m_mem;
            // B lanes first, then A lanes on top: A wins any lane both ports write.
            for (int l = 0; l < 2; l++)
                if (ENB && WEB[l]) m_mem[ADDRB][8*l +: 8] = DIB[8*l +: 8];
            for (int l = 0; l < 2; l++)
                if (ENA && WEA[l]) m_mem[ADDRA][8*l +: 8] = DIA[8*l +: 8];
            m_coll = ENA && ENB && (ADDRA == ADDRB) && ((WEA & WEB) != 2'b00);
            if (ENA) begin
                m_doa0 = (WEA != 2'b00) ? m_mem[ADDRA] : old[ADDRA];
                m_doa1 = old[ADDRA];
            end
            if (ENB) begin
                m_dob0 = (WEB != 2'b00) ? m_mem[ADDRB] : old[ADDRB];
                m_dob1 = old[ADDRB];
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic ena, input logic [1:0] wea,
                       input logic [3:0] adda, input logic [15:0] dia,
                       input logic enb, input logic [1:0] web,
                       input logic [3:0] addb, input logic [15:0] dib);
        RESET = rst; ENA = ena; WEA = wea; ADDRA = adda; DIA = dia;
        ENB = enb; WEB = web; ADDRB = addb; DIB = dib;
        @(posedge CLOCK);
        model_step();
        #1;
        chk("rdy0", {15'd0, rdy0}, {15'd0, m_rdy});
        chk("rdy1", {15'd0, rdy1}, {15'd0, m_rdy});
        chk("coll0", {15'd0, coll0}, {15'd0, m_coll});
        chk("coll1", {15'd0, coll1}, {15'd0, m_coll});
        chk("doa_wf", doa0, m_doa0);
        chk("dob_wf", dob0, m_dob0);
        chk("doa_rf", doa1, m_doa1);
        chk("dob_rf", dob1, m_dob1);
    endtask

    task automatic rand_cyc(input logic rst);
        logic [3:0] a;
        a = 4'($urandom);
        cyc(rst, $urandom_range(0, 3) != 0, 2'($urandom), a, 16'($urandom),
            $urandom_range(0, 3) != 0, 2'($urandom),
            ($urandom_range(0, 2) == 0) ? a : 4'($urandom), 16'($urandom));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0, 2'b00, 4'd0, 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;

        // Clear sweep with port traffic ignored; RDY rises on the 16th edge after release.
        cyc(1'b1, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0, 2'b00, 4'd0, 16'd0);
        chk("reset_rdy", {15'd0, rdy0}, 16'd0);
        chk("reset_doa", doa0, 16'd0);
        for (int i = 0; i < 15; i++) rand_cyc(1'b0);
        chk("rdy_before_16", {15'd0, rdy0}, 16'd0);
        idle();
        chk("rdy_at_16", {15'd0, rdy0}, 16'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 4'(i), 16'd0, 1'b1, 2'b00, 4'(15 - i), 16'd0);
            chk("clear_val", doa0, INIT);
        end

        // Byte enables and ENA=0 hold
        cyc(1'b0, 1'b1, 2'b11, 4'd3, 16'h1234, 1'b0, 2'b00, 4'd0, 16'd0);
        cyc(1'b0, 1'b1, 2'b01, 4'd3, 16'hABCD, 1'b0, 2'b00, 4'd0, 16'd0);
        cyc(1'b0, 1'b1, 2'b00, 4'd3, 16'h0000, 1'b0, 2'b00, 4'd0, 16'd0);
        chk("byte_merge", doa0, 16'h12CD);
        cyc(1'b0, 1'b0, 2'b11, 4'd3, 16'hFFFF, 1'b0, 2'b00, 4'd0, 16'd0);
        chk("ena0_hold", doa0, 16'h12CD);

        // Read-during-write
        cyc(1'b0, 1'b1, 2'b11, 4'd5, 16'h0000, 1'b0, 2'b00, 4'd0, 16'd0);
        cyc(1'b0, 1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b1, 2'b00, 4'd5, 16'd0);
        chk("rdw_wf_a", doa0, 16'hBEEF);
        chk("rdw_rf_a", doa1, 16'h0000);
        chk("rdw_wf_b", dob0, 16'h0000);
        chk("rdw_rf_b", dob1, 16'h0000);

        // Full collision, then lane merge
        cyc(1'b0, 1'b1, 2'b11, 4'd7, 16'h1111, 1'b1, 2'b11, 4'd7, 16'h2222);
        chk("coll_pulse", {15'd0, coll0}, 16'd1);
        chk("coll_dob_wf", dob0, 16'h1111);
        cyc(1'b0, 1'b1, 2'b00, 4'd7, 16'h0000, 1'b0, 2'b00, 4'd0, 16'd0);
        chk("coll_drop", {15'd0, coll0}, 16'd0);
        chk("coll_word", doa0, 16'h1111);
        cyc(1'b0, 1'b1, 2'b10, 4'd7, 16'hAB00, 1'b1, 2'b01, 4'd7, 16'h00CD);
        chk("merge_nocoll", {15'd0, coll0}, 16'd0);
        cyc(1'b0, 1'b1, 2'b00, 4'd7, 16'h0000, 1'b0, 2'b00, 4'd0, 16'd0);
        chk("merge_word", doa0, 16'hABCD);

        for (int i = 0; i < 400; i++) rand_cyc(1'b0);

        // Reset mid-sweep at ptr=9, then mid-traffic with both ports writing
        cyc(1'b1, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0, 2'b00, 4'd0, 16'd0);
        for (int i = 0; i < 9; i++) rand_cyc(1'b0);
        cyc(1'b1, 1'b1, 2'b11, 4'd2, 16'h5555, 1'b1, 2'b11, 4'd9, 16'h6666);
        for (int i = 0; i < 16; i++) rand_cyc(1'b0);
        chk("resweep_rdy", {15'd0, rdy0}, 16'd1);
        for (int i = 0; i < 100; i++) rand_cyc(1'b0);
        cyc(1'b1, 1'b1, 2'b11, 4'd4, 16'h7777, 1'b1, 2'b11, 4'd4, 16'h8888);
        chk("reset_coll", {15'd0, coll0}, 16'd0);
        for (int i = 0; i < 16; i++) rand_cyc(1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 2'b00, 4'(i), 16'd0, 1'b1, 2'b00, 4'(i), 16'd0);
            chk("final_clear", dob1, INIT);
        end
        for (int i = 0; i < 200; i++) rand_cyc(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_be_clr.md
Name: dpram_be_clr

Overview:
Single-clock, true dual-port register RAM for the Modbus slave register map. It is the parametrised successor to the two-port RAM. It adds per-byte write enables, a selectable read-during-write mode and deterministic same-address collision arbitration with a collision flag. On reset it automatically sweeps every word to an init value. Port A serves the Modbus frame engine and port B serves the application side.

Parameters:
A_WIDTH, 4, address width; depth N = 2**A_WIDTH words
D_WIDTH, 16, data width; must be a multiple of 8; B = D_WIDTH/8 byte lanes
RD_MODE, 0, same-port read-during-write: 0 = write-first (new data), 1 = read-first (old data)
INIT_VAL, 0, D_WIDTH-bit value written to every word by the clear sweep

Ports:
CLOCK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
ENA  in  1  port A enable
WEA  in  B  port A byte write enables, bit i covers DIA[8i+7:8i]
ADDRA  in  A_WIDTH  port A address
DIA  in  D_WIDTH  port A write data
DOA  out  D_WIDTH  port A registered read data
ENB  in  1  port B enable
WEB  in  B  port B byte write enables
ADDRB  in  A_WIDTH  port B address
DIB  in  D_WIDTH  port B write data
DOB  out  D_WIDTH  port B registered read data
RDY  out  1  high when the clear sweep is complete and ports are accepted
COLL  out  1  one-cycle pulse: same-address, same-lane write collision occurred

Behaviour:
- Reset (one clock, synchronous, active-high): on any edge with RESET=1:
  - DOA=0, DOB=0, RDY=0, COLL=0.
  - State goes to CLEAR and the sweep pointer goes to 0.
  - No RAM write takes place.
- States: CLEAR and READY.
- CLEAR:
  - Each edge with RESET=0 writes INIT_VAL to address ptr, then increments ptr.
  - The edge that writes address N-1 moves the state to READY and sets RDY=1.
  - RDY therefore rises on the N-th edge after RESET is released.
  - Port inputs are ignored. DOA, DOB and COLL stay 0.
- Reset mid-operation: RESET in any state, including mid-sweep, restarts the sweep at address 0. RDY drops on that edge.
- READY, per port x:
  - ENx=0: no access, DOx holds its value.
  - ENx=1: read latency is 1 cycle; DOx updates on the edge that samples the request.
  - Write: byte lane i of RAM[ADDRx] is replaced by DIx lane i iff WEx[i]=1. Other lanes are unchanged.
  - Same-port readback with RD_MODE=0: DOx = word as stored after the edge, including the merge and any collision result.
  - Same-port readback with RD_MODE=1: DOx = word before the edge.
  - Cross-port read of an address the other port writes on the same edge returns the pre-edge word, in both modes.
- Collision: ENA=ENB=1 and ADDRA==ADDRB.
  - Each lane takes A's byte if WEA[i]=1, else B's byte if WEB[i]=1, else keeps the old byte.
  - COLL=1 for exactly the one cycle after any lane has WEA[i]=WEB[i]=1. Otherwise COLL=0.
  - Disjoint lane writes to the same address merge without raising COLL.
- Different addresses: both ports operate independently on the same edge.
- Storage is inferable as RAM. Byte merge and arbitration are resolved before the single write per address per edge.

Test Plan:
- Clear sweep: A_WIDTH=4, INIT_VAL=16'hA5A5, pulse RESET 1 cycle -> RDY rises on edge 16 after release. Reading all 16 addresses on A returns A5A5. Port writes issued while RDY=0 have no effect.
- Byte enables: write DIA=16'h1234 with WEA=2'b11 to addr 3, then DIA=16'hABCD with WEA=2'b01 -> read addr 3 returns 12CD one cycle after the request. Toggling ENA=0 holds DOA.
- Read-during-write: addr 5 holds 0000, write 16'hBEEF on A with DOA sampled on the same edge -> RD_MODE=0 gives DOA=BEEF, RD_MODE=1 gives DOA=0000. Port B reading addr 5 on that edge gets 0000 in both modes.
- Full collision: addr 7, A writes 1111 (WEA=11), B writes 2222 (WEB=11) on the same edge -> RAM[7]=1111 and COLL high exactly one cycle. Write-first DOB=1111.
- Lane merge: addr 7, WEA=2'b10 with DIA=AB00, WEB=2'b01 with DIB=00CD on the same edge -> RAM[7]=ABCD and COLL stays 0.
- Reset mid-sweep and mid-traffic: assert RESET at sweep ptr=9, then again during READY with both ports writing -> sweep restarts at 0, RDY low for 16 edges. DOA, DOB and COLL are 0 during the sweep, and all words end at INIT_VAL.
